// File: rtl/codec_pkg.sv
// rtl/codec_pkg.sv - shared types and constants for the codec serial-audio slave
package codec_pkg;

  // Default sample width; also the number of bit clocks per LRCLK half-period.
  localparam int DATA_W_DEF = 16;

  // Bit counter must hold 0..DATA_W inclusive so a full half-frame is distinguishable.
  localparam int CNT_W_DEF = $clog2(DATA_W_DEF + 1);

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    LFT  = 2'd1,
    RHT  = 2'd2
  } state_t;

  function automatic int cnt_width(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/edge_sync.sv
// rtl/edge_sync.sv - multi-flop synchronizer with registered rise/fall detection
module edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  // Never fewer than two flops, whatever the caller asks for.
  localparam int N = (STAGES < 2) ? 2 : STAGES;

  logic [N-1:0] sync_q;
  logic         prev_q;
  // Fills with ones after reset; edges are suppressed until the chain and the
  // previous-sample flop both reflect the real pin, so a pin that is already
  // high at reset release is not mistaken for a rising edge.
  logic [N:0]   arm_q;

  // Shift the pin through the chain and keep one extra sample for edge compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      arm_q  <= '0;
    end else begin
      sync_q <= {sync_q[N-2:0], d_i};
      prev_q <= sync_q[N-1];
      arm_q  <= {arm_q[N-1:0], 1'b1};
    end
  end

  assign level_o = sync_q[N-1];
  assign rise_o  = arm_q[N] &  sync_q[N-1] & ~prev_q;
  assign fall_o  = arm_q[N] & ~sync_q[N-1] &  prev_q;

endmodule

// File: rtl/codec_i2s_slave.sv
// rtl/codec_i2s_slave.sv - codec-side serial audio slave: SDout serializer, SDin deserializer
module codec_i2s_slave
  import codec_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SCLK,
  input  logic              LRCLK,
  input  logic              SDin,
  output logic              SDout,
  input  logic [DATA_W-1:0] tx_lft,
  input  logic [DATA_W-1:0] tx_rht,
  output logic              tx_rdy,
  output logic [DATA_W-1:0] rx_lft,
  output logic [DATA_W-1:0] rx_rht,
  output logic              rx_vld,
  output logic              frame_err
);

  localparam int              CNT_W = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DATA_W);

  logic sclk_rise, sclk_fall, sclk_level_unused;
  logic lr_rise, lr_fall, lr_level_unused;
  logic sdin_s, sdin_rise_unused, sdin_fall_unused;

  edge_sync #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (SCLK),
    .level_o(sclk_level_unused),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  edge_sync #(.STAGES(SYNC_STAGES)) u_lrclk_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (LRCLK),
    .level_o(lr_level_unused),
    .rise_o (lr_rise),
    .fall_o (lr_fall)
  );

  edge_sync #(.STAGES(SYNC_STAGES)) u_sdin_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (SDin),
    .level_o(sdin_s),
    .rise_o (sdin_rise_unused),
    .fall_o (sdin_fall_unused)
  );

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0]   hold_rht_q, hold_rht_d;
  logic                sdout_q, sdout_d;
  logic                tx_rdy_q, tx_rdy_d;
  logic [DATA_W-1:0]   rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0]   pend_lft_q, pend_lft_d;
  logic                pend_vld_q, pend_vld_d;
  logic [DATA_W-1:0]   rx_lft_q, rx_lft_d;
  logic [DATA_W-1:0]   rx_rht_q, rx_rht_d;
  logic                rx_vld_q, rx_vld_d;
  logic                frame_err_q, frame_err_d;

  // Next-state: bit-level shifting first, then LRCLK handling overrides it so a
  // coincident SCLK fall never shifts the freshly loaded word.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tx_sr_d     = tx_sr_q;
    hold_rht_d  = hold_rht_q;
    sdout_d     = sdout_q;
    tx_rdy_d    = 1'b0;
    rx_sr_d     = rx_sr_q;
    pend_lft_d  = pend_lft_q;
    pend_vld_d  = pend_vld_q;
    rx_lft_d    = rx_lft_q;
    rx_rht_d    = rx_rht_q;
    rx_vld_d    = 1'b0;
    frame_err_d = frame_err_q;

    // Receive: sample on SCLK rise; bits past a full word are dropped.
    if (sclk_rise && (cnt_q != FULL)) begin
      rx_sr_d = {rx_sr_q[DATA_W-2:0], sdin_s};
      cnt_d   = cnt_q + 1'b1;
    end

    // Transmit: advance on SCLK fall; zeros follow once the word is exhausted.
    if (sclk_fall && (state_q != SYNC)) begin
      tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
      sdout_d = tx_sr_q[DATA_W-2];
    end

    if (lr_rise && (state_q != LFT)) begin
      // Start of a frame: take both samples now so left and right belong together.
      state_d    = LFT;
      hold_rht_d = tx_rht;
      tx_sr_d    = tx_lft;
      sdout_d    = tx_lft[DATA_W-1];
      tx_rdy_d   = 1'b1;
      cnt_d      = '0;
      if (state_q == RHT) begin
        if (cnt_q == FULL) begin
          if (pend_vld_q) begin
            rx_lft_d = pend_lft_q;
            rx_rht_d = rx_sr_q;
            rx_vld_d = 1'b1;
          end
        end else begin
          frame_err_d = 1'b1;
        end
        pend_vld_d = 1'b0;
      end
    end else if (lr_fall && (state_q == LFT)) begin
      // Left half done: park the left word until its right partner completes.
      state_d = RHT;
      tx_sr_d = hold_rht_q;
      sdout_d = hold_rht_q[DATA_W-1];
      cnt_d   = '0;
      if (cnt_q == FULL) begin
        pend_lft_d = rx_sr_q;
        pend_vld_d = 1'b1;
      end else begin
        pend_vld_d  = 1'b0;
        frame_err_d = 1'b1;
      end
    end
  end

  // State and registered outputs; reset drops any partial words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SYNC;
      cnt_q       <= '0;
      tx_sr_q     <= '0;
      hold_rht_q  <= '0;
      sdout_q     <= 1'b0;
      tx_rdy_q    <= 1'b0;
      rx_sr_q     <= '0;
      pend_lft_q  <= '0;
      pend_vld_q  <= 1'b0;
      rx_lft_q    <= '0;
      rx_rht_q    <= '0;
      rx_vld_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tx_sr_q     <= tx_sr_d;
      hold_rht_q  <= hold_rht_d;
      sdout_q     <= sdout_d;
      tx_rdy_q    <= tx_rdy_d;
      rx_sr_q     <= rx_sr_d;
      pend_lft_q  <= pend_lft_d;
      pend_vld_q  <= pend_vld_d;
      rx_lft_q    <= rx_lft_d;
      rx_rht_q    <= rx_rht_d;
      rx_vld_q    <= rx_vld_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign SDout     = sdout_q;
  assign tx_rdy    = tx_rdy_q;
  assign rx_lft    = rx_lft_q;
  assign rx_rht    = rx_rht_q;
  assign rx_vld    = rx_vld_q;
  assign frame_err = frame_err_q;

endmodule

// File: doc/codec_i2s_slave.md
Name: codec_i2s_slave

Overview:
Synthesizable CODEC-side endpoint of the Equalizer's serial audio link. It is the responder to the Equalizer's codec interface master: it obeys the externally generated SCLK/LRCLK, serializes stereo samples onto SDout, and deserializes the Equalizer's SDin stream into parallel left/right words. It replaces the behavioural CS4272 model in FPGA loopback builds and serves as the reusable slave in block-level benches.

Parameters:
DATA_W, 16, bits per channel sample; also the number of SCLK periods per LRCLK half-period
SYNC_STAGES, 2, synchronizer flops on SCLK, LRCLK and SDin (minimum 2)

Ports:
clk  input  1  system clock; all state is on its rising edge
rst  input  1  asynchronous, active-high reset
SCLK  input  1  serial bit clock from the Equalizer (nominally clk/32)
LRCLK  input  1  frame clock from the Equalizer (nominally clk/1024); 1 = left, 0 = right
SDin  input  1  serial data from the Equalizer (DAC direction)
SDout  output  1  serial data to the Equalizer (ADC direction)
tx_lft  input  DATA_W  left sample to transmit next frame
tx_rht  input  DATA_W  right sample to transmit next frame
tx_rdy  output  1  one-clk pulse: tx_lft/tx_rht captured; source may advance
rx_lft  output  DATA_W  last complete left word received
rx_rht  output  DATA_W  last complete right word received
rx_vld  output  1  one-clk pulse: rx_lft/rx_rht updated as a coherent pair
frame_err  output  1  sticky: malformed half-frame detected

Behaviour:
- Reset (asynchronous, immediate): SDout=0, tx_rdy=0, rx_lft=rx_rht=0, rx_vld=0, frame_err=0, state=SYNC, bit count=0, synchronizers cleared. Reset mid-frame discards partial words; no rx_vld is produced for them.
- SCLK, LRCLK and SDin each pass through SYNC_STAGES flops; edges are detected by comparing the last two synchronized samples. All decisions use synchronized signals only.
- Format: left-justified, MSB first. LRCLK and SDout change on SCLK falling edge; data is sampled on SCLK rising edge. First rising SCLK after an LRCLK edge carries the MSB.
- States: SYNC -> LFT on first LRCLK rising edge after reset (LRCLK falling in SYNC is ignored); LFT -> RHT on LRCLK falling; RHT -> LFT on LRCLK rising.
- LRCLK rising edge (entering LFT): capture tx_lft/tx_rht into holding registers, pulse tx_rdy for exactly 1 clk, load left word into TX shift register, SDout = its MSB in the next clk.
- LRCLK falling edge (entering RHT): load held right word; SDout = its MSB next clk.
- SCLK falling edge within a half-frame (except the one coincident with the LRCLK edge): shift TX register left, SDout = next bit; after DATA_W bits, shift in 0.
- SCLK rising edge: shift synchronized SDin into RX register LSB-first-in; bit count increments, saturating at DATA_W; rises beyond DATA_W are ignored.
- End of LFT half (LRCLK falling): if count == DATA_W, RX word goes to a pending-left register. End of RHT half (LRCLK rising): if count == DATA_W and pending-left valid, update rx_lft and rx_rht on the same clk and pulse rx_vld 1 clk later at most; the pair is never torn.
- Frame error: LRCLK edge with count != DATA_W outside SYNC sets frame_err (sticky until rst); the affected pair produces no rx_vld; the TX sequence continues normally.
- Simultaneous LRCLK edge and SCLK falling edge: LRCLK handling (load) wins; no shift that clk.
- Latency: SDout MSB valid SYNC_STAGES+1 clks after the LRCLK pin edge; rx_vld within SYNC_STAGES+2 clks of LRCLK rising.

Decomposition:
- Package codec_pkg: DATA_W default, state enum {SYNC, LFT, RHT}, bit-count width constant.
- One sub-module: edge_sync (SYNC_STAGES flop chain plus rise/fall pulses), instantiated for SCLK, LRCLK and SDin (SDin uses level output only).

Test Plan:
- Reset, then drive 3 frames at clk/32 SCLK, clk/1024 LRCLK with SDin encoding L=16'h1234, R=16'hABCD -> rx_vld pulses once per frame starting at frame 1, rx_lft=16'h1234, rx_rht=16'hABCD.
- tx_lft=16'h8001, tx_rht=16'h7FFE -> SDout bitstream sampled on SCLK rises equals 8001 then 7FFE, MSB first; tx_rdy exactly one pulse per LRCLK rise.
- Reset released while LRCLK low mid-right-half -> no rx_vld and no tx_rdy until the first LRCLK rise; first rx_vld only after a full L+R frame.
- One half-frame truncated to 12 SCLK periods -> frame_err=1 and stays 1, that pair gets no rx_vld, next good frame still delivers rx_vld with correct data.
- Assert rst for 3 clks mid-left-half after rx_lft=16'h1234 -> all outputs 0 immediately, resync on the next LRCLK rise.
- Swept values 16'h0000, 16'hFFFF, 16'h8000 loopback (SDout tied to SDin through the Equalizer-side master model) -> rx words equal tx words delayed by exactly one frame.
